// File: rtl/radio_frame_deser.sv
// Serial sample-link deserializer: SYNC-aligned 8-bit words, HUNT/ACQ/LOCK framing.
// Optional ERR_COUNT port and counter when RADIO_DESER_ERRCNT_EN is defined.
module radio_frame_deser #(
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned MISS_LIMIT  = 2
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       DATA_IN,
  input  logic       SYNC_IN,
  output logic [7:0] SAMPLE_OUT,
  output logic       SAMPLE_VALID,
  output logic       LOCKED
`ifdef RADIO_DESER_ERRCNT_EN
  ,
  output logic [15:0] ERR_COUNT
`endif
);

  typedef enum logic [1:0] {
    HUNT,
    ACQ,
    LOCK
  } state_t;

  localparam logic [3:0] LF = 4'(LOCK_FRAMES);
  localparam logic [3:0] ML = 4'(MISS_LIMIT);

  state_t     state_q, state_d;
  logic       d_q, s_q;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [3:0] good_q, good_d;
  logic [3:0] miss_q, miss_d;
  logic       done_q, done_d;
  logic [7:0] out_q;
  logic       vld_q;
  logic       bnd;

  assign bnd  = (bcnt_q == 3'd0);
  assign sr_d = {d_q, sr_q[7:1]};

  always_ff @(posedge SYS_CLK) begin
    if (RST) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT: if (s_q) state_d = (LF == 4'd1) ? LOCK : ACQ;
      ACQ: begin
        if (bnd && !s_q)
          state_d = HUNT;
        else if (bnd && (good_q + 4'd1 == LF))
          state_d = LOCK;
      end
      LOCK: begin
        if (bnd && !s_q && (miss_q + 4'd1 == ML))
          state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    LOCKED = (state_q == LOCK);
  end

  always_comb begin
    bcnt_d = bcnt_q + 3'd1;
    good_d = good_q;
    miss_d = miss_q;
    done_d = 1'b0;
    unique case (state_q)
      HUNT: begin
        bcnt_d = s_q ? 3'd1 : 3'd0;
        good_d = {3'd0, s_q};
        miss_d = 4'd0;
      end
      ACQ: begin
        if (bnd) begin
          if (s_q) begin
            good_d = good_q + 4'd1;
          end else begin
            bcnt_d = 3'd0;
            good_d = 4'd0;
          end
        end else if (s_q) begin
          // realign: this slot becomes bit 0 of a new frame
          bcnt_d = 3'd1;
          good_d = 4'd1;
        end
      end
      LOCK: begin
        done_d = (bcnt_q == 3'd7);
        if (bnd) begin
          if (s_q) begin
            miss_d = 4'd0;
          end else if (miss_q + 4'd1 == ML) begin
            miss_d = 4'd0;
            bcnt_d = 3'd0;
          end else begin
            miss_d = miss_q + 4'd1;
          end
        end
      end
      default: begin
        bcnt_d = 3'd0;
        good_d = 4'd0;
        miss_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      d_q    <= 1'b0;
      s_q    <= 1'b0;
      sr_q   <= 8'h00;
      bcnt_q <= 3'd0;
      good_q <= 4'd0;
      miss_q <= 4'd0;
      done_q <= 1'b0;
      out_q  <= 8'h00;
      vld_q  <= 1'b0;
    end else begin
      d_q    <= DATA_IN;
      s_q    <= SYNC_IN;
      sr_q   <= sr_d;
      bcnt_q <= bcnt_d;
      good_q <= good_d;
      miss_q <= miss_d;
      done_q <= done_d;
      vld_q  <= done_q;
      if (done_q) out_q <= sr_q;
    end
  end

  assign SAMPLE_OUT   = out_q;
  assign SAMPLE_VALID = vld_q;

`ifdef RADIO_DESER_ERRCNT_EN
  logic [15:0] err_q;
  logic        err_inc;

  // in LOCK a SYNC is wrong exactly when its presence differs from the boundary
  assign err_inc = (state_q == LOCK) && (s_q != bnd);

  always_ff @(posedge SYS_CLK) begin
    if (RST)
      err_q <= 16'h0000;
    else if (err_inc && (err_q != 16'hFFFF))
      err_q <= err_q + 16'h0001;
  end

  assign ERR_COUNT = err_q;
`endif

endmodule
